// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetch with a PC/instruction FIFO
//            toward decode; a branch redirect flushes buffered and in-flight
//            fetches.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int PC_SIZE     = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_SIZE-1:0]     pc_in,
    input  logic                   redirect,
    output logic                   if_ready,
    output logic                   mem_req_valid,
    output logic [PC_SIZE-1:0]     mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_resp_data,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_SIZE-1:0]     id_pc,
    input  logic                   id_ready
);

    localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PC_SIZE-1:0]     r_req_pc;
    logic [INSTR_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
    logic [PC_SIZE-1:0]     r_pc_mem    [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_PTR_W:0]       r_count;
    logic [c_PTR_W:0]       w_count_next;
    logic                   w_req_valid;
    logic                   w_hs;
    logic                   w_id_valid;
    logic                   w_push;
    logic                   w_pop;

    // Gating with reset keeps the next-PC register from advancing during reset.
    assign w_req_valid = (r_state == S_REQ) && !redirect && !reset;
    assign w_hs        = w_req_valid && mem_req_ready;
    assign w_id_valid  = (r_count != '0) && !redirect && !reset;
    assign w_pop       = w_id_valid && id_ready;
    assign w_push      = (r_state == S_WAIT) && mem_resp_valid && !redirect;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count < c_DEPTH) && !redirect) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    w_state_next = S_IDLE;
                end else if (w_hs) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_state_next = mem_resp_valid ? S_IDLE : S_DROP;
                end else if (mem_resp_valid) begin
                    w_state_next = (w_count_next < c_DEPTH) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (mem_resp_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hs) begin
                r_req_pc <= pc_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
            end
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_instr_mem[r_wptr] <= mem_resp_data;
                r_pc_mem[r_wptr]    <= r_req_pc;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    assign if_ready      = w_hs;
    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = pc_in;
    assign id_valid      = w_id_valid;
    assign id_instr      = r_instr_mem[r_rptr];
    assign id_pc         = r_pc_mem[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Bench for instr_fetch with a next-PC model, a latency-programmable
//            memory responder and an in-order delivery scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [63:0] pc_in;
    logic        redirect;
    logic        if_ready;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_ready;

    instr_fetch #(.PC_SIZE(64), .INSTR_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .redirect       (redirect),
        .if_ready       (if_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        idr;
        logic        mrv;
        logic        ifr;
        logic        idv;
        logic [63:0] idpc;
        logic [31:0] idi;
    } vec_t;

    ent_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_hs   = 0;
    int          n_pop  = 0;
    int          lat    = 1;
    int          pend_cnt = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_data = '0;
    logic        use_dead = 1'b0;
    logic [63:0] redir_target = '0;
    logic [63:0] last_pop_pc  = '0;
    logic        s_mrv, s_ifr, s_idv;
    logic [63:0] s_addr, s_idpc;
    logic [31:0] s_idi;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return 32'hA5A5A5A5 ^ {a[15:0], a[15:0]} ^ 32'h10001000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: sample/score at negedge, advance environment models after the edge.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        s_mrv  = mem_req_valid;
        s_ifr  = if_ready;
        s_idv  = id_valid;
        s_addr = mem_req_addr;
        s_idpc = id_pc;
        s_idi  = id_instr;
        chk("req_addr", mem_req_addr, pc_in);
        if (reset || redirect) begin
            exp_q.delete();
        end else begin
            if (id_valid && id_ready) begin
                n_pop++;
                last_pop_pc = id_pc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual pc=%h instr=%h required none", id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", id_pc, e.pc);
                    chk("pop_instr", {32'h0, id_instr}, {32'h0, e.instr});
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                n_hs++;
                e.pc      = pc_in;
                e.instr   = use_dead ? 32'h0000DEAD : mem_fn(pc_in);
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_data = e.instr;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (redirect) pc_in = redir_target;
            else if (s_ifr) pc_in = pc_in + 64'd4;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = pend_data;
                    pend           = 1'b0;
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] pc);
        reset = 1'b1;
        pc_in = pc;
        tick();
        reset = 1'b0;
        n_hs  = 0;
        n_pop = 0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int k = 0;
        while (n_hs < target && k < budget) begin
            tick();
            k++;
        end
        chk("wait_hs_count", 64'(n_hs), 64'(target));
    endtask

    vec_t tbl[10];

    initial begin
        reset = 1'b1; pc_in = 64'h1000; redirect = 1'b0; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = '0; id_ready = 1'b0;

        //        rst idr mrv ifr idv  id_pc        id_instr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    32'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    32'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    32'h0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1000, 32'hA5A5A5A5};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1000, 32'hA5A5A5A5};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1000, 32'hA5A5A5A5};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1000, 32'hA5A5A5A5};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h1004, 32'hA5A1A5A1};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1008, 32'hA5ADA5AD};

        @(posedge clk);
        #1;
        tick();
        for (int i = 0; i < 10; i++) begin
            reset    = tbl[i].rst;
            id_ready = tbl[i].idr;
            tick();
            chk("tbl_mem_req_valid", 64'(s_mrv), 64'(tbl[i].mrv));
            chk("tbl_if_ready", 64'(s_ifr), 64'(tbl[i].ifr));
            chk("tbl_id_valid", 64'(s_idv), 64'(tbl[i].idv));
            if (tbl[i].idv || tbl[i].rst) begin
                chk("tbl_id_pc", s_idpc, tbl[i].idpc);
                chk("tbl_id_instr", {32'h0, s_idi}, {32'h0, tbl[i].idi});
            end
        end

        // Fill to capacity with decode stalled, then drain in order.
        id_ready = 1'b0; lat = 1;
        do_reset(64'h1000);
        repeat (15) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_no_req", 64'(s_mrv), 64'h0);
        end
        chk("full_entries", 64'(n_hs), 64'd4);
        chk("full_head_pc", s_idpc, 64'h1000);
        id_ready = 1'b1;
        n_pop = 0;
        repeat (12) tick();
        chk("drain_pops", 64'(n_pop >= 4), 64'h1);
        chk("fetch_resumed", 64'(n_hs > 4), 64'h1);

        // Memory back-pressure: request held stable for five cycles.
        mem_req_ready = 1'b0;
        do_reset(64'h3000);
        tick();
        tick();
        chk("stall_req_valid", 64'(s_mrv), 64'h1);
        chk("stall_addr0", s_addr, 64'h3000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req_valid", 64'(s_mrv), 64'h1);
            chk("stall_addr", s_addr, 64'h3000);
            chk("stall_if_ready", 64'(s_ifr), 64'h0);
        end
        mem_req_ready = 1'b1;
        tick();
        chk("stall_accept", 64'(s_ifr), 64'h1);
        chk("stall_accept_addr", s_addr, 64'h3000);

        // Redirect in WAIT; the late response is dropped.
        lat = 4; use_dead = 1'b1;
        do_reset(64'h1000);
        wait_hs(1, 10);
        redirect = 1'b1; redir_target = 64'h2000;
        tick();
        use_dead = 1'b0;
        chk("redir_id_valid", 64'(s_idv), 64'h0);
        chk("redir_req_valid", 64'(s_mrv), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drop_req_valid", 64'(s_mrv), 64'h0);
            chk("drop_id_valid", 64'(s_idv), 64'h0);
        end
        tick();
        chk("redir_new_req", 64'(s_mrv), 64'h1);
        chk("redir_new_addr", s_addr, 64'h2000);
        n_pop = 0;
        for (int k = 0; k < 20 && n_pop == 0; k++) tick();
        chk("redir_first_pc", last_pop_pc, 64'h2000);

        // Redirect coincident with a response, two entries buffered.
        lat = 1; id_ready = 1'b0;
        do_reset(64'h1000);
        wait_hs(3, 20);
        redirect = 1'b1; redir_target = 64'h4000;
        tick();
        chk("coinc_id_valid", 64'(s_idv), 64'h0);
        chk("coinc_req_valid", 64'(s_mrv), 64'h0);
        tick();
        chk("coinc_empty", 64'(s_idv), 64'h0);
        chk("coinc_idle", 64'(s_mrv), 64'h0);
        tick();
        chk("coinc_req_target", 64'(s_mrv), 64'h1);
        chk("coinc_addr_target", s_addr, 64'h4000);

        // Reset mid-WAIT with three entries buffered.
        lat = 3; id_ready = 1'b0;
        do_reset(64'h1000);
        wait_hs(4, 40);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rstwait_id_valid", 64'(s_idv), 64'h0);
        chk("rstwait_req_valid", 64'(s_mrv), 64'h0);
        tick();
        chk("rstwait_req_again", 64'(s_mrv), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the next-PC register. It takes the current fetch address `pc_in`, issues one instruction-memory read per instruction with a valid/ready request handshake, and buffers returned instructions with their PCs in a small FIFO for decode. Each accepted memory request pulses `if_ready` back to the next-PC register so it advances by 4. A branch redirect from execute (the same strobe that loads the branch target into the next-PC register) flushes all buffered and in-flight fetches.

## Interface
- PC_SIZE, 64, PC/address width
- INSTR_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, ≥2

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_in  in  PC_SIZE  current fetch PC from the next-PC register
- redirect  in  1  branch taken; flush, and the next-PC register loads the target this cycle
- if_ready  out  1  one-cycle pulse: `pc_in` consumed; the next-PC register increments
- mem_req_valid  out  1  read request valid
- mem_req_addr  out  PC_SIZE  read address, equals `pc_in`
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  read data valid, one pulse per accepted request
- mem_resp_data  in  INSTR_WIDTH  instruction word
- id_valid  out  1  instruction available to decode
- id_instr  out  INSTR_WIDTH  FIFO head instruction
- id_pc  out  PC_SIZE  FIFO head PC
- id_ready  in  1  decode accepts the head

## Operation
- Control FSM states:
  - IDLE: no request outstanding.
  - REQ: request presented.
  - WAIT: request accepted, awaiting response.
  - DROP: awaiting a response that will be discarded.
- At most one memory request is outstanding at any time.
- IDLE → REQ when `count < FIFO_DEPTH` and `!redirect`.
- REQ outputs:
  - `mem_req_valid = !redirect`.
  - `mem_req_addr = pc_in`.
  - `if_ready = mem_req_valid && mem_req_ready`.
- REQ transitions:
  - On handshake, latch `req_pc <= pc_in` and go to WAIT.
  - On `redirect`, go to IDLE.
- WAIT, on `mem_resp_valid` without `redirect`:
  - Push `{req_pc, mem_resp_data}` into the FIFO.
  - Go to REQ if `count_next < FIFO_DEPTH`, else IDLE.
- WAIT, on `redirect`:
  - Go to DROP, or to IDLE if `mem_resp_valid` is also high in that cycle. That response is discarded.
- DROP: on `mem_resp_valid`, discard the data and go to IDLE. A `redirect` while in DROP keeps the state in DROP.
- FIFO:
  - `id_valid = !empty && !redirect`.
  - `id_instr`/`id_pc` come from the head entry.
  - Pop when `id_valid && id_ready`.
  - Push and pop in the same cycle are both honoured, and count is unchanged.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. `count` is `log2(FIFO_DEPTH)+1` bits.
- `redirect` has priority over everything:
  - FIFO pointers and count clear at the edge.
  - No push or pop occurs.
  - `if_ready` = 0.
- Full FIFO: never enter REQ, so a response always has a free slot. No overflow is possible by construction.
- Empty FIFO: `id_valid` = 0, and `id_ready` is ignored.
- `mem_resp_valid` in IDLE or REQ is a protocol error; ignore it.

## Timing
- Reset (synchronous, priority over `redirect`):
  - State = IDLE, FIFO empty, storage cleared to 0.
  - `id_valid` = 0, `id_instr` = 0, `id_pc` = 0.
  - `mem_req_valid` = 0, `if_ready` = 0.
  - `mem_req_addr` follows `pc_in` combinationally at all times.
- A reset in any state, including WAIT or DROP, abandons the in-flight request. Memory is reset in the same cycle.
- After reset deasserts: first cycle in IDLE, second cycle in REQ with `mem_req_valid` = 1.
- Handshake in cycle N:
  - `if_ready` = 1 in cycle N, and `pc_in` updates in N+1.
  - Earliest response is N+1. It is pushed at the end of N+1, and `id_valid` = 1 in N+2.
- Peak throughput: one instruction per 2 cycles with single-cycle memory (REQ, WAIT, REQ, ...).
- Redirect in cycle R:
  - `id_valid` and `mem_req_valid` are 0 in R.
  - FIFO is empty in R+1.
  - A new request for the target is issued no earlier than R+2 from IDLE, or after the DROP response.

## Test plan
- Reset, `pc_in` = 0x1000, `mem_req_ready`=1, response 1 cycle later with 0xA5A5A5A5 → `if_ready` pulses in cycle 2; `id_valid`=1 with `id_pc`=0x1000, `id_instr`=0xA5A5A5A5 in cycle 4.
- Hold `id_ready`=0 and stream PCs 0x1000, 0x1004, ... → exactly 4 entries buffered, then `mem_req_valid` stays 0. Raise `id_ready` → entries drain in order 0x1000..0x100C and fetching resumes.
- `mem_req_ready` low for 5 cycles → `mem_req_valid` held, `mem_req_addr` stable, `if_ready` 0 until the accept cycle.
- Redirect while in WAIT, response arrives 3 cycles later with 0xDEAD → response dropped, FIFO empty. The next request address is the target 0x2000, and `id_pc`=0x2000 is delivered first.
- Redirect in the same cycle as `mem_resp_valid`, with 2 entries buffered → nothing pushed, FIFO empty next cycle, state IDLE.
- Reset asserted mid-WAIT with 3 entries buffered → next cycle `id_valid`=0, `mem_req_valid`=0, state IDLE.
